// File: rtl/traffic_lane.sv
// One road lane: NUM_CARS equally spaced cars moving on a wrapping grid, with
// a per-column occupancy bitmap and a registered single-cycle collision probe.
module traffic_lane #(
  parameter int unsigned          GRID_W      = 20,
  parameter int unsigned          X_BITS      = 5,
  parameter int unsigned          NUM_CARS    = 3,
  parameter int unsigned          CAR_SPACING = 6,
  parameter int unsigned          CAR_LEN     = 2,
  parameter int unsigned          CNT_BITS    = 24,
  parameter logic [CNT_BITS-1:0]  BASE_PERIOD = 24'd1000000,
  parameter bit                   DIRECTION   = 1'b1
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset,
  input  logic                         i_Enable,
  input  logic [2:0]                   i_Level,
  input  logic                         i_Probe_Valid,
  input  logic [X_BITS-1:0]            i_Probe_X,
  output logic [NUM_CARS*X_BITS-1:0]   o_Car_X,
  output logic [GRID_W-1:0]            o_Occupancy,
  output logic                         o_Step,
  output logic                         o_Hit
);

  typedef logic [NUM_CARS-1:0][X_BITS-1:0] cars_t;

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);

  function automatic cars_t rst_cars();
    cars_t cars;
    for (int unsigned k = 0; k < NUM_CARS; k++) begin
      cars[k] = X_BITS'((k * CAR_SPACING) % GRID_W);
    end
    return cars;
  endfunction

  // Each car covers its head plus CAR_LEN-1 cells trailing behind it.
  function automatic logic [GRID_W-1:0] occ_of(input cars_t cars);
    logic [GRID_W-1:0] occ;
    int unsigned h;
    int unsigned c;
    occ = '0;
    for (int unsigned k = 0; k < NUM_CARS; k++) begin
      h = 32'(cars[k]);
      for (int unsigned l = 0; l < CAR_LEN; l++) begin
        if (DIRECTION) c = (h >= l) ? h - l : h + GRID_W - l;
        else           c = (h + l < GRID_W) ? h + l : h + l - GRID_W;
        occ = occ | (GRID_W'(1) << c);
      end
    end
    return occ;
  endfunction

  logic [CNT_BITS-1:0]       cnt_q, cnt_d;
  cars_t                     car_q, car_d;
  logic [GRID_W-1:0]         occ_q;
  logic                      step_q, hit_q, hit_d;
  logic [CNT_BITS-1:0]       per_w;
  logic                      step_w;
  logic [(1<<X_BITS)-1:0]    occ_ext;

  always_comb begin
    per_w = BASE_PERIOD >> i_Level;
    if (per_w == '0) per_w = CNT_BITS'(1);
  end

  // >= rather than == so a mid-count level increase steps at once instead of wrapping.
  assign step_w = i_Enable && (cnt_q >= per_w - CNT_BITS'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_Enable) cnt_d = step_w ? '0 : cnt_q + CNT_BITS'(1);
  end

  always_comb begin
    car_d = car_q;
    if (step_w) begin
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        if (DIRECTION) car_d[k] = (car_q[k] == X_MAX) ? '0 : car_q[k] + X_BITS'(1);
        else           car_d[k] = (car_q[k] == '0) ? X_MAX : car_q[k] - X_BITS'(1);
      end
    end
  end

  // Columns beyond the grid read as empty, so out-of-range probes miss.
  always_comb begin
    occ_ext = '0;
    occ_ext[GRID_W-1:0] = occ_q;
  end

  assign hit_d = i_Probe_Valid & occ_ext[i_Probe_X];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q  <= '0;
      car_q  <= rst_cars();
      occ_q  <= occ_of(rst_cars());
      step_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      car_q  <= car_d;
      occ_q  <= occ_of(car_d);
      step_q <= step_w;
      hit_q  <= hit_d;
    end
  end

  assign o_Car_X     = car_q;
  assign o_Occupancy = occ_q;
  assign o_Step      = step_q;
  assign o_Hit       = hit_q;

endmodule

// File: tb/tb_traffic_lane.sv
// Bench for traffic_lane: a right-moving lane (BASE_PERIOD=8) and a
// left-moving lane (BASE_PERIOD=1) checked against a step-count reference model.
module tb_traffic_lane;

  localparam int G  = 20;
  localparam int XB = 5;
  localparam int NC = 3;
  localparam int SP = 6;
  localparam int CL = 2;
  localparam int BP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, pv;
  logic [2:0]        lvl;
  logic [XB-1:0]     px;
  logic [NC*XB-1:0]  carx;
  logic [G-1:0]      occ;
  logic              stp, hit;

  logic              b_rst, b_en, b_pv;
  logic [2:0]        b_lvl;
  logic [XB-1:0]     b_px;
  logic [NC*XB-1:0]  b_carx;
  logic [G-1:0]      b_occ;
  logic              b_stp, b_hit;

  traffic_lane #(.GRID_W(G), .X_BITS(XB), .NUM_CARS(NC), .CAR_SPACING(SP), .CAR_LEN(CL),
                 .CNT_BITS(24), .BASE_PERIOD(24'd8), .DIRECTION(1'b1)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Level(lvl),
    .i_Probe_Valid(pv), .i_Probe_X(px),
    .o_Car_X(carx), .o_Occupancy(occ), .o_Step(stp), .o_Hit(hit));

  traffic_lane #(.GRID_W(G), .X_BITS(XB), .NUM_CARS(NC), .CAR_SPACING(SP), .CAR_LEN(CL),
                 .CNT_BITS(24), .BASE_PERIOD(24'd1), .DIRECTION(1'b0)) dut_left (
    .i_Clk(clk), .i_Reset(b_rst), .i_Enable(b_en), .i_Level(b_lvl),
    .i_Probe_Valid(b_pv), .i_Probe_X(b_px),
    .o_Car_X(b_carx), .o_Occupancy(b_occ), .o_Step(b_stp), .o_Hit(b_hit));

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: total steps taken (mod G) fully determines positions.
  int m_cnt, m_steps, b_steps;
  bit m_step, m_hit, b_step;

  function automatic logic [NC*XB-1:0] exp_carx(input int steps, input bit dir);
    logic [NC*XB-1:0] v;
    int h;
    v = '0;
    for (int k = 0; k < NC; k++) begin
      h = (k*SP + (dir ? steps : G - steps)) % G;
      v[k*XB +: XB] = XB'(h);
    end
    return v;
  endfunction

  function automatic logic [G-1:0] exp_occ(input int steps, input bit dir);
    logic [G-1:0] v;
    int h, c;
    v = '0;
    for (int k = 0; k < NC; k++) begin
      h = (k*SP + (dir ? steps : G - steps)) % G;
      for (int l = 0; l < CL; l++) begin
        c = dir ? (h - l + G) % G : (h + l) % G;
        v = v | (G'(1) << c);
      end
    end
    return v;
  endfunction

  task automatic cyc();
    int p, n_cnt, n_steps, nb_steps;
    bit n_step, n_hit, nb_step;
    logic [G-1:0] o;
    p = BP >> lvl;
    if (p == 0) p = 1;
    o = exp_occ(m_steps, 1'b1);
    n_cnt = m_cnt; n_steps = m_steps; n_step = 1'b0;
    n_hit = (pv === 1'b1 && int'(px) < G) ? o[px] : 1'b0;
    if (en) begin
      if (m_cnt >= p - 1) begin
        n_cnt = 0; n_steps = (m_steps + 1) % G; n_step = 1'b1;
      end else begin
        n_cnt = m_cnt + 1;
      end
    end
    if (rst) begin
      n_cnt = 0; n_steps = 0; n_step = 1'b0; n_hit = 1'b0;
    end
    nb_steps = b_steps; nb_step = 1'b0;
    if (b_rst) nb_steps = 0;
    else if (b_en) begin nb_steps = (b_steps + 1) % G; nb_step = 1'b1; end
    @(posedge clk);
    #1;
    m_cnt = n_cnt; m_steps = n_steps; m_step = n_step; m_hit = n_hit;
    b_steps = nb_steps; b_step = nb_step;
  endtask

  task automatic test_reset();
    rst = 1'b1; b_rst = 1'b1; en = 1'b1; b_en = 1'b0; lvl = 3'd1; pv = 1'b1; px = 5'd6;
    cyc(); cyc();
    n_checks++; if (carx !== {5'd12, 5'd6, 5'd0}) begin n_errors++; $display("FAIL reset_carx got %h want %h", carx, {5'd12, 5'd6, 5'd0}); end
    n_checks++; if (occ !== 20'h81861) begin n_errors++; $display("FAIL reset_occ got %h want %h", occ, 20'h81861); end
    n_checks++; if (stp !== 1'b0) begin n_errors++; $display("FAIL reset_step got %b want 0", stp); end
    n_checks++; if (hit !== 1'b0) begin n_errors++; $display("FAIL reset_hit got %b want 0", hit); end
    n_checks++; if (b_occ !== 20'h030C3) begin n_errors++; $display("FAIL reset_left_occ got %h want %h", b_occ, 20'h030C3); end
    rst = 1'b0; pv = 1'b0;
  endtask

  task automatic test_first_step();
    lvl = 3'd1; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_checks++; if (stp !== (i == 4)) begin n_errors++; $display("FAIL first_step edge %0d got %b want %b", i, stp, i == 4); end
    end
    n_checks++; if (carx !== {5'd13, 5'd7, 5'd1}) begin n_errors++; $display("FAIL first_step_carx got %h want %h", carx, {5'd13, 5'd7, 5'd1}); end
    n_checks++; if (occ !== exp_occ(1, 1'b1)) begin n_errors++; $display("FAIL first_step_occ got %h want %h", occ, exp_occ(1, 1'b1)); end
  endtask

  task automatic test_wrap_right();
    lvl = 3'd7; en = 1'b1;
    for (int i = 0; i < G; i++) begin
      cyc();
      n_checks++; if (carx !== exp_carx(m_steps, 1'b1) || stp !== 1'b1) begin n_errors++; $display("FAIL wrap_right cyc %0d got %h/%b want %h/1", i, carx, stp, exp_carx(m_steps, 1'b1)); end
      n_checks++; if (occ !== exp_occ(m_steps, 1'b1)) begin n_errors++; $display("FAIL wrap_right_occ cyc %0d got %h want %h", i, occ, exp_occ(m_steps, 1'b1)); end
      if (m_steps == 0) begin
        n_checks++; if (carx !== {5'd12, 5'd6, 5'd0} || occ[0] !== 1'b1 || occ[19] !== 1'b1) begin n_errors++; $display("FAIL wrap_right_home got %h occ %h", carx, occ); end
      end
    end
  endtask

  task automatic test_wrap_left();
    b_rst = 1'b1; cyc();
    b_rst = 1'b0; b_en = 1'b1;
    for (int i = 0; i < G; i++) begin
      cyc();
      n_checks++; if (b_carx !== exp_carx(b_steps, 1'b0) || b_stp !== 1'b1) begin n_errors++; $display("FAIL wrap_left cyc %0d got %h/%b want %h/1", i, b_carx, b_stp, exp_carx(b_steps, 1'b0)); end
      n_checks++; if (b_occ !== exp_occ(b_steps, 1'b0)) begin n_errors++; $display("FAIL wrap_left_occ cyc %0d got %h want %h", i, b_occ, exp_occ(b_steps, 1'b0)); end
      if (b_steps == 1) begin
        n_checks++; if (b_carx[4:0] !== 5'd19 || b_occ[19] !== 1'b1 || b_occ[0] !== 1'b1) begin n_errors++; $display("FAIL wrap_left_edge got %h occ %h", b_carx, b_occ); end
      end
    end
    n_checks++; if (b_hit !== 1'b0) begin n_errors++; $display("FAIL wrap_left_hit got %b want 0", b_hit); end
    b_en = 1'b0;
  endtask

  task automatic test_level_change();
    rst = 1'b1; cyc();
    rst = 1'b0; lvl = 3'd0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++; if (stp !== 1'b0) begin n_errors++; $display("FAIL level_pre cyc %0d got %b want 0", i, stp); end
    end
    lvl = 3'd2; cyc();
    n_checks++; if (stp !== 1'b1 || carx !== {5'd13, 5'd7, 5'd1}) begin n_errors++; $display("FAIL level_jump got %b/%h want 1/%h", stp, carx, {5'd13, 5'd7, 5'd1}); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++; if (stp !== (i % 2 == 1) || stp !== m_step) begin n_errors++; $display("FAIL level2 cyc %0d got %b want %b", i, stp, i % 2 == 1); end
    end
    lvl = 3'd7;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++; if (stp !== 1'b1 || carx !== exp_carx(m_steps, 1'b1)) begin n_errors++; $display("FAIL level7 cyc %0d got %b/%h want 1/%h", i, stp, carx, exp_carx(m_steps, 1'b1)); end
    end
  endtask

  task automatic test_pause();
    logic [NC*XB-1:0] snap_x;
    logic [G-1:0]     snap_o;
    int               waited;
    rst = 1'b1; cyc();
    rst = 1'b0; lvl = 3'd0; en = 1'b1;
    repeat (3) cyc();
    snap_x = exp_carx(0, 1'b1); snap_o = exp_occ(0, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++; if (carx !== snap_x || occ !== snap_o || stp !== 1'b0) begin n_errors++; $display("FAIL pause cyc %0d got %h/%h/%b want %h/%h/0", i, carx, occ, stp, snap_x, snap_o); end
    end
    en = 1'b1; waited = 0;
    do begin cyc(); waited++; end while (stp !== 1'b1 && waited < 20);
    n_checks++; if (waited != 5) begin n_errors++; $display("FAIL pause_resume got %0d cycles want 5", waited); end
  endtask

  task automatic test_probe();
    logic [XB-1:0] xs [5] = '{5'd6, 5'd3, 5'd25, 5'd0, 5'd19};
    bit            hs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; cyc();
    rst = 1'b0; en = 1'b0; pv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      px = xs[i]; cyc();
      n_checks++; if (hit !== hs[i]) begin n_errors++; $display("FAIL probe x=%0d got %b want %b", xs[i], hit, hs[i]); end
    end
    pv = 1'b0; cyc();
    n_checks++; if (hit !== 1'b0) begin n_errors++; $display("FAIL probe_idle got %b want 0", hit); end
    en = 1'b1; lvl = 3'd7; pv = 1'b1; px = 5'd5; cyc();
    n_checks++; if (hit !== 1'b1 || stp !== 1'b1 || occ[5] !== 1'b0) begin n_errors++; $display("FAIL probe_step got hit %b step %b occ5 %b want 1 1 0", hit, stp, occ[5]); end
    pv = 1'b0; en = 1'b0; cyc();
  endtask

  task automatic test_reset_mid();
    int waited;
    rst = 1'b1; cyc();
    rst = 1'b0; lvl = 3'd1; en = 1'b1;
    repeat (12) cyc();
    n_checks++; if (carx !== {5'd15, 5'd9, 5'd3}) begin n_errors++; $display("FAIL rmid_pre got %h want %h", carx, {5'd15, 5'd9, 5'd3}); end
    repeat (2) cyc();
    rst = 1'b1; pv = 1'b1; px = 5'd3; cyc();
    n_checks++; if (carx !== {5'd12, 5'd6, 5'd0} || hit !== 1'b0 || stp !== 1'b0) begin n_errors++; $display("FAIL rmid_reset got %h/%b/%b want %h/0/0", carx, hit, stp, {5'd12, 5'd6, 5'd0}); end
    rst = 1'b0; pv = 1'b0; waited = 0;
    do begin cyc(); waited++; end while (stp !== 1'b1 && waited < 20);
    n_checks++; if (waited != 4) begin n_errors++; $display("FAIL rmid_period got %0d cycles want 4", waited); end
  endtask

  task automatic test_random();
    rst = 1'b1; cyc();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      en  = ($urandom_range(0, 3) != 0);
      lvl = 3'($urandom_range(0, 7));
      pv  = $urandom_range(0, 1) != 0;
      px  = 5'($urandom_range(0, 31));
      cyc();
      n_checks++; if (carx !== exp_carx(m_steps, 1'b1) || occ !== exp_occ(m_steps, 1'b1)) begin n_errors++; $display("FAIL random_pos cyc %0d got %h/%h want %h/%h", i, carx, occ, exp_carx(m_steps, 1'b1), exp_occ(m_steps, 1'b1)); end
      n_checks++; if (stp !== m_step || hit !== m_hit) begin n_errors++; $display("FAIL random_pulse cyc %0d got step %b hit %b want %b %b", i, stp, hit, m_step, m_hit); end
    end
    rst = 1'b0; pv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; lvl = '0; pv = 1'b0; px = '0;
    b_rst = 1'b1; b_en = 1'b0; b_lvl = '0; b_pv = 1'b0; b_px = '0;
    m_cnt = 0; m_steps = 0; m_step = 1'b0; m_hit = 1'b0; b_steps = 0; b_step = 1'b0;
    test_reset();
    test_first_step();
    test_wrap_right();
    test_wrap_left();
    test_level_change();
    test_pause();
    test_probe();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_lane.md
Name: traffic_lane

Overview:
Parametrised successor to the single-car mover. One instance drives an entire road lane with NUM_CARS equally spaced cars of CAR_LEN cells on a wrapping grid. It adds:
- enable/pause control
- a run-time speed level
- a per-cell occupancy bitmap
- a registered collision probe used by the frog/game-state logic

One instance is placed per lane in the top level. The display and collision logic consume its outputs.

Parameters:
GRID_W, 20, number of grid columns; legal 2..2^X_BITS
X_BITS, 5, width of one X coordinate
NUM_CARS, 3, cars in the lane; legal 1..8
CAR_SPACING, 6, columns between consecutive car heads; NUM_CARS*CAR_SPACING <= GRID_W
CAR_LEN, 2, cells per car; legal 1..CAR_SPACING
BASE_PERIOD, 24'd1000000, enabled clock cycles per step at level 0; >= 1
CNT_BITS, 24, width of speed counter; must hold BASE_PERIOD
DIRECTION, 1, 1 = move right (+X), 0 = move left (-X)

Ports:
i_Clk  in  1  system clock; all logic on rising edge
i_Reset  in  1  synchronous, active-high reset
i_Enable  in  1  1 = lane runs; 0 = counter and positions frozen
i_Level  in  3  speed level; effective period = max(1, BASE_PERIOD >> i_Level)
i_Probe_Valid  in  1  collision query strobe
i_Probe_X  in  X_BITS  column queried
o_Car_X  out  NUM_CARS*X_BITS  head X of car k at bits [k*X_BITS +: X_BITS]
o_Occupancy  out  GRID_W  bit c = 1 if any car covers column c
o_Step  out  1  one-cycle pulse in the cycle positions change
o_Hit  out  1  registered probe result

Behaviour:
- Reset (i_Reset=1 at an edge, overrides everything):
  - counter = 0
  - car k head = (k*CAR_SPACING) mod GRID_W
  - o_Occupancy = bitmap of those reset positions
  - o_Step = 0, o_Hit = 0
  - Reset mid-count or mid-probe discards all pending state.
- Period: P = BASE_PERIOD >> i_Level, forced to 1 if the result is 0. i_Level is sampled every cycle.
- Counter, when i_Enable=1 and not in reset:
  - if counter >= P-1: counter = 0 and a step occurs;
  - otherwise counter increments.
  - The >= compare makes a level increase that leaves counter > P-1 step on the next enabled edge, with no wrap through 2^CNT_BITS.
- i_Enable=0: counter, positions and o_Occupancy hold; o_Step = 0. Probes still work.
- Step (all cars move simultaneously):
  - DIRECTION=1: x = (x == GRID_W-1) ? 0 : x+1
  - DIRECTION=0: x = (x == 0) ? GRID_W-1 : x-1
  - X arithmetic must never produce a value >= GRID_W.
- Latency:
  - o_Car_X is the position register itself, with no extra pipeline stage.
  - o_Occupancy is registered from next-state positions, so it changes on the same edge as o_Car_X.
  - o_Step is high exactly for the cycle following a stepping edge.
  - At level 0 with P=BASE_PERIOD, the first step after reset occurs on the BASE_PERIOD-th enabled edge.
- Occupancy: car with head h covers h and the CAR_LEN-1 cells trailing it opposite to travel, with modular wrap.
  - DIRECTION=1: h, h-1, ...
  - DIRECTION=0: h, h+1, ...
  - Overlap cannot occur under the legal parameter rules.
- Probe:
  - On an edge with i_Probe_Valid=1: o_Hit = o_Occupancy[i_Probe_X] as held before that edge, i.e. the bitmap visible in the probe cycle.
  - i_Probe_X >= GRID_W gives o_Hit = 0.
  - On an edge with i_Probe_Valid=0: o_Hit = 0.
  - o_Hit is therefore a 1-cycle-latency pulse per probe. A probe coinciding with a step sees the pre-step bitmap.
- Back-to-back probes each produce their own result in consecutive cycles.

Test Plan:
1. Defaults except BASE_PERIOD=4, i_Level=0, i_Enable=1, reset released.
   -> Initial heads 0, 6, 12; o_Occupancy = bits {0, 19, 5, 6, 11, 12}.
   -> First o_Step after 4 enabled edges; heads become 1, 7, 13.
2. DIRECTION=1, BASE_PERIOD=1: run 20 steps.
   -> Car 0 goes 19 then 0, heads return to 0, 6, 12.
   -> Check o_Occupancy[0]=1 and [19]=1 while head = 0.
   Repeat with DIRECTION=0: head 0 goes to 19, covering 19 and 0.
3. BASE_PERIOD=8: run 6 cycles at level 0, then set i_Level=2 (P=2).
   -> Step on the next edge with counter reset to 0; thereafter a step every 2 cycles.
   -> i_Level=7 gives P=1, a step every cycle.
4. Drop i_Enable for 10 cycles mid-count.
   -> o_Car_X, counter and o_Occupancy unchanged; o_Step = 0.
   -> On re-enable, stepping resumes with the remaining count.
5. Probes:
   - i_Probe_X=6 at reset positions -> o_Hit=1 next cycle.
   - i_Probe_X=3 -> o_Hit=0.
   - i_Probe_X=25 -> o_Hit=0.
   - Probe issued in a stepping cycle -> reflects the pre-step bitmap.
6. Assert i_Reset for 1 cycle mid-period after heads reach 3, 9, 15.
   -> Next cycle: heads 0, 6, 12, o_Hit=0, o_Step=0, counter restarts (a full P to the next step).
